// File: rtl/la_pkg.sv
// Shared definitions for the Gauss-Jordan inversion control path.
package la_pkg;

    localparam int unsigned N_DEF  = 5;
    localparam int unsigned DW_DEF = 8;

    typedef enum logic [1:0] {
        OP_INIT = 2'b00,
        OP_SWAP = 2'b01,
        OP_ELIM = 2'b10
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_PIV_RD,
        ST_PIV_CHK,
        ST_SRCH_RD,
        ST_SRCH_CHK,
        ST_SWAP,
        ST_ELIM,
        ST_NEXT,
        ST_FIN
    } seq_state_e;

endpackage

// File: rtl/gj_cmd_reg.sv
// Row-engine command holding register: loads when empty or on transfer,
// holds the payload while the engine applies backpressure.
module gj_cmd_reg #(
    parameter int unsigned PW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [PW-1:0] i_payload,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [PW-1:0] o_payload
);

    logic          r_valid;
    logic [PW-1:0] r_payload;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (!r_valid || i_ready) begin
            r_valid <= i_push;
            if (i_push) begin
                r_payload <= i_payload;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_payload = r_payload;

endmodule

// File: rtl/gj_elim_sequencer.sv
// Gauss-Jordan inversion sequencer: walks pivots, searches for swap rows on a
// zero pivot, and issues INIT/SWAP/ELIM commands to the row engine.
module gj_elim_sequencer
    import la_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned RW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          singular,
    output logic [RW-1:0] rd_row,
    output logic [RW-1:0] rd_col,
    input  logic [DW-1:0] rd_data,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [1:0]    cmd_op,
    output logic [RW-1:0] cmd_dst,
    output logic [RW-1:0] cmd_src,
    output logic [RW-1:0] cmd_col
);

    typedef struct packed {
        logic [1:0]    op;
        logic [RW-1:0] dst;
        logic [RW-1:0] src;
        logic [RW-1:0] col;
    } cmd_t;

    localparam int unsigned   CW     = $bits(cmd_t);
    localparam logic [RW-1:0] LAST   = RW'(N - 1);
    localparam logic [RW:0]   LAST_W = (RW + 1)'(N - 1);

    seq_state_e    r_state, w_state_nxt;
    logic [RW-1:0] r_k, w_k_nxt;
    logic [RW-1:0] r_r, w_r_nxt;
    logic [RW-1:0] r_j, w_j_nxt;
    logic [RW-1:0] r_rd_row, w_rd_row_nxt;
    logic [RW-1:0] r_rd_col, w_rd_col_nxt;
    logic          r_busy, r_done, r_singular, w_sing_nxt;
    logic          w_push, w_xfer, w_nz;
    logic [RW:0]   w_r_inc, w_r_skip;
    logic [RW-1:0] w_r_first;
    cmd_t          w_cmd_d, w_cmd_q;

    assign w_xfer    = cmd_valid & cmd_ready;
    assign w_nz      = |rd_data;
    assign w_r_inc   = {1'b0, r_r} + (RW + 1)'(1);
    // Next elimination row, stepping over the pivot row in the same cycle
    assign w_r_skip  = (w_r_inc == {1'b0, r_k}) ? w_r_inc + (RW + 1)'(1) : w_r_inc;
    assign w_r_first = (r_k == '0) ? RW'(1) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_r        <= '0;
            r_j        <= '0;
            r_rd_row   <= '0;
            r_rd_col   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_singular <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_k        <= w_k_nxt;
            r_r        <= w_r_nxt;
            r_j        <= w_j_nxt;
            r_rd_row   <= w_rd_row_nxt;
            r_rd_col   <= w_rd_col_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FIN);
            r_done     <= (w_state_nxt == ST_FIN);
            r_singular <= w_sing_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_k_nxt      = r_k;
        w_r_nxt      = r_r;
        w_j_nxt      = r_j;
        w_rd_row_nxt = r_rd_row;
        w_rd_col_nxt = r_rd_col;
        w_sing_nxt   = r_singular;
        w_push       = 1'b0;
        w_cmd_d      = '0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_INIT;
                    w_k_nxt     = '0;
                    w_r_nxt     = '0;
                    w_sing_nxt  = 1'b0;
                    w_push      = 1'b1;
                    w_cmd_d.op  = OP_INIT;
                end
            end
            ST_INIT: begin
                if (w_xfer) begin
                    if (r_r == LAST) begin
                        w_state_nxt  = ST_PIV_RD;
                        w_rd_row_nxt = r_k;
                        w_rd_col_nxt = r_k;
                    end else begin
                        w_r_nxt     = r_r + RW'(1);
                        w_push      = 1'b1;
                        w_cmd_d.op  = OP_INIT;
                        w_cmd_d.dst = r_r + RW'(1);
                    end
                end
            end
            ST_PIV_RD: begin
                w_state_nxt = ST_PIV_CHK;
            end
            ST_PIV_CHK: begin
                if (w_nz) begin
                    w_state_nxt = ST_ELIM;
                    w_r_nxt     = w_r_first;
                    w_push      = 1'b1;
                    w_cmd_d.op  = OP_ELIM;
                    w_cmd_d.dst = w_r_first;
                    w_cmd_d.src = r_k;
                    w_cmd_d.col = r_k;
                end else if (r_k == LAST) begin
                    w_state_nxt = ST_FIN;
                    w_sing_nxt  = 1'b1;
                end else begin
                    w_state_nxt  = ST_SRCH_RD;
                    w_j_nxt      = r_k + RW'(1);
                    w_rd_row_nxt = r_k + RW'(1);
                    w_rd_col_nxt = r_k;
                end
            end
            ST_SRCH_RD: begin
                w_state_nxt = ST_SRCH_CHK;
            end
            ST_SRCH_CHK: begin
                if (w_nz) begin
                    w_state_nxt = ST_SWAP;
                    w_push      = 1'b1;
                    w_cmd_d.op  = OP_SWAP;
                    w_cmd_d.dst = r_k;
                    w_cmd_d.src = r_j;
                end else if (r_j != LAST) begin
                    w_state_nxt  = ST_SRCH_RD;
                    w_j_nxt      = r_j + RW'(1);
                    w_rd_row_nxt = r_j + RW'(1);
                end else begin
                    w_state_nxt = ST_FIN;
                    w_sing_nxt  = 1'b1;
                end
            end
            ST_SWAP: begin
                if (w_xfer) begin
                    w_state_nxt  = ST_PIV_RD;
                    w_rd_row_nxt = r_k;
                    w_rd_col_nxt = r_k;
                end
            end
            ST_ELIM: begin
                if (w_xfer) begin
                    if (w_r_skip > LAST_W) begin
                        w_state_nxt = ST_NEXT;
                    end else begin
                        w_r_nxt     = w_r_skip[RW-1:0];
                        w_push      = 1'b1;
                        w_cmd_d.op  = OP_ELIM;
                        w_cmd_d.dst = w_r_skip[RW-1:0];
                        w_cmd_d.src = r_k;
                        w_cmd_d.col = r_k;
                    end
                end
            end
            ST_NEXT: begin
                if (r_k == LAST) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_state_nxt  = ST_PIV_RD;
                    w_k_nxt      = r_k + RW'(1);
                    w_rd_row_nxt = r_k + RW'(1);
                    w_rd_col_nxt = r_k + RW'(1);
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    gj_cmd_reg #(
        .PW(CW)
    ) u_cmd_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_payload (w_cmd_d),
        .i_ready   (cmd_ready),
        .o_valid   (cmd_valid),
        .o_payload (w_cmd_q)
    );

    assign cmd_op   = w_cmd_q.op;
    assign cmd_dst  = w_cmd_q.dst;
    assign cmd_src  = w_cmd_q.src;
    assign cmd_col  = w_cmd_q.col;
    assign busy     = r_busy;
    assign done     = r_done;
    assign singular = r_singular;
    assign rd_row   = r_rd_row;
    assign rd_col   = r_rd_col;

endmodule

// File: tb/tb_gj_elim_sequencer.sv
// Directed bench for gj_elim_sequencer with a row-permuting matrix read model.
module tb_gj_elim_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy, done, singular;
    logic [2:0] rd_row, rd_col;
    logic [7:0] rd_data = 8'd0;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_dst, cmd_src, cmd_col;

    gj_elim_sequencer u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .singular  (singular),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_data   (rd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_src   (cmd_src),
        .cmd_col   (cmd_col)
    );

    always #5 clk = ~clk;

    logic [7:0]  mat [5][5];
    int          perm [5];
    logic [10:0] log_cmd [64];
    logic [5:0]  addr_q [$];
    logic [5:0]  prev_addr, after_swap_addr;
    logic        after_swap_pend;
    int          n_cmd, n_init, n_swap, n_elim, n_done, n_tgt_pres, n_tgt_xfer;
    int          stalled;
    logic        stall_en;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Row-permuted element read, one cycle latency
    always @(posedge clk) rd_data <= mat[perm[rd_row]][rd_col];

    always @(negedge clk) begin
        if (!rst_n) begin
            n_cmd = 0; n_init = 0; n_swap = 0; n_elim = 0; n_done = 0;
            n_tgt_pres = 0; n_tgt_xfer = 0;
            addr_q.delete();
            prev_addr = 6'd0; after_swap_addr = 6'h3f; after_swap_pend = 1'b0;
            for (int i = 0; i < 5; i++) perm[i] = i;
        end else begin
            if (after_swap_pend) begin
                after_swap_addr = {rd_row, rd_col};
                after_swap_pend = 1'b0;
            end
            if ({rd_row, rd_col} != prev_addr) begin
                prev_addr = {rd_row, rd_col};
                addr_q.push_back(prev_addr);
            end
            if (done) n_done++;
            if (cmd_valid && cmd_op == 2'd2 && cmd_dst == 3'd3 && cmd_src == 3'd1 && cmd_col == 3'd1)
                n_tgt_pres++;
            if (cmd_valid && cmd_ready) begin
                if (n_cmd < 64) log_cmd[n_cmd] = {cmd_op, cmd_dst, cmd_src, cmd_col};
                n_cmd++;
                if (cmd_op == 2'd0) n_init++;
                if (cmd_op == 2'd2) n_elim++;
                if (cmd_op == 2'd2 && cmd_dst == 3'd3 && cmd_src == 3'd1 && cmd_col == 3'd1)
                    n_tgt_xfer++;
                if (cmd_op == 2'd1) begin
                    int tmp;
                    n_swap++;
                    tmp = perm[cmd_dst];
                    perm[cmd_dst] = perm[cmd_src];
                    perm[cmd_src] = tmp;
                    after_swap_pend = 1'b1;
                end
            end
        end
    end

    // Row-engine ready: optional 3-cycle stall on ELIM(3,1,1)
    initial begin
        cmd_ready = 1'b1;
        stalled   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) stalled = 0;
            if (stall_en && stalled < 3 && cmd_valid && cmd_op == 2'd2 &&
                cmd_dst == 3'd3 && cmd_src == 3'd1 && cmd_col == 3'd1) begin
                cmd_ready = 1'b0;
                stalled++;
            end else begin
                cmd_ready = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, 32'(ok), 32'd1);
    endtask

    task automatic load_identity();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                mat[r][c] = (r == c) ? 8'd1 : 8'd0;
    endtask

    task automatic check_elim_k(input string tag, input int base, input int k);
        int idx = base;
        for (int r = 0; r < 5; r++) begin
            if (r != k) begin
                check_eq(tag, 32'(log_cmd[idx]), 32'({2'd2, 3'(r), 3'(k), 3'(k)}));
                idx++;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        stall_en = 1'b0;
        load_identity();

        // Reset state
        tick();
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_singular", 32'(singular), 32'd0);
        check_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_rd_addr", 32'({rd_row, rd_col}), 32'd0);
        check_eq("rst_cmd_payload", 32'({cmd_op, cmd_dst, cmd_src, cmd_col}), 32'd0);
        rst_n = 1'b1;

        // 1: identity, always ready
        load_identity();
        do_reset();
        pulse_start();
        check_eq("t1_busy_after_start", 32'(busy), 32'd1);
        wait_done("t1_done_seen", 300);
        check_eq("t1_busy_in_fin", 32'(busy), 32'd0);
        tick();
        check_eq("t1_n_cmd", 32'(n_cmd), 32'd25);
        check_eq("t1_n_swap", 32'(n_swap), 32'd0);
        check_eq("t1_n_done", 32'(n_done), 32'd1);
        check_eq("t1_singular", 32'(singular), 32'd0);
        for (int i = 0; i < 5; i++)
            check_eq("t1_init", 32'(log_cmd[i]), 32'({2'd0, 3'(i), 3'd0, 3'd0}));
        for (int k = 0; k < 5; k++)
            check_elim_k("t1_elim", 5 + 4 * k, k);
        repeat (3) tick();
        check_eq("t1_done_single", 32'(n_done), 32'd1);

        // 2: zero pivot, rows 0/2 swapped
        load_identity();
        mat[0][0] = 8'd0; mat[0][2] = 8'd1;
        mat[2][0] = 8'd7; mat[2][2] = 8'd0;
        do_reset();
        pulse_start();
        wait_done("t2_done_seen", 300);
        tick();
        check_eq("t2_n_cmd", 32'(n_cmd), 32'd26);
        check_eq("t2_n_swap", 32'(n_swap), 32'd1);
        check_eq("t2_swap_cmd", 32'(log_cmd[5]), 32'({2'd1, 3'd0, 3'd2, 3'd0}));
        check_eq("t2_srch_rd1", 32'(addr_q[0]), 32'({3'd1, 3'd0}));
        check_eq("t2_srch_rd2", 32'(addr_q[1]), 32'({3'd2, 3'd0}));
        check_eq("t2_reread_q", 32'(addr_q[2]), 32'({3'd0, 3'd0}));
        check_eq("t2_reread_after_swap", 32'(after_swap_addr), 32'({3'd0, 3'd0}));
        check_elim_k("t2_elim_k0", 6, 0);
        check_eq("t2_singular", 32'(singular), 32'd0);

        // 3: column 1 zero below k=0
        load_identity();
        mat[1][1] = 8'd0;
        do_reset();
        pulse_start();
        wait_done("t3_done_seen", 300);
        check_eq("t3_singular_with_done", 32'(singular), 32'd1);
        tick();
        check_eq("t3_n_init", 32'(n_init), 32'd5);
        check_eq("t3_n_elim", 32'(n_elim), 32'd4);
        check_eq("t3_n_swap", 32'(n_swap), 32'd0);
        check_eq("t3_n_cmd", 32'(n_cmd), 32'd9);
        check_eq("t3_addr_count", 32'(addr_q.size()), 32'd4);
        for (int j = 1; j < 5; j++)
            check_eq("t3_srch_addr", 32'(addr_q[j-1]), 32'({3'(j), 3'd1}));
        repeat (3) tick();
        check_eq("t3_singular_held", 32'(singular), 32'd1);
        check_eq("t3_n_done", 32'(n_done), 32'd1);

        // 4: backpressure on ELIM(3,1,1)
        load_identity();
        do_reset();
        stall_en = 1'b1;
        pulse_start();
        wait_done("t4_done_seen", 300);
        tick();
        stall_en = 1'b0;
        check_eq("t4_stall_cycles", 32'(stalled), 32'd3);
        check_eq("t4_tgt_present", 32'(n_tgt_pres), 32'd4);
        check_eq("t4_tgt_xfer", 32'(n_tgt_xfer), 32'd1);
        check_eq("t4_n_cmd", 32'(n_cmd), 32'd25);
        check_elim_k("t4_elim_k1", 9, 1);

        // 5: reset mid-ELIM at k=2
        load_identity();
        do_reset();
        pulse_start();
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (cmd_valid && cmd_op == 2'd2 && cmd_src == 3'd2) begin
                    hit = 1'b1;
                    break;
                end
                tick();
            end
            check_eq("t5_reach_k2", 32'(hit), 32'd1);
        end
        rst_n = 1'b0;
        tick();
        check_eq("t5_busy_after_rst", 32'(busy), 32'd0);
        check_eq("t5_valid_after_rst", 32'(cmd_valid), 32'd0);
        check_eq("t5_done_after_rst", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        check_eq("t5_quiet_after_rst", 32'(n_cmd), 32'd0);
        pulse_start();
        check_eq("t5_restart_cmd", 32'({cmd_valid, cmd_op, cmd_dst}), 32'({1'b1, 2'd0, 3'd0}));
        wait_done("t5_done_seen", 300);
        tick();
        check_eq("t5_n_cmd", 32'(n_cmd), 32'd25);
        check_eq("t5_first_elim", 32'(log_cmd[5]), 32'({2'd2, 3'd1, 3'd0, 3'd0}));
        check_eq("t5_n_done", 32'(n_done), 32'd1);

        // 6: start while busy and in FIN ignored; accepted right after FIN
        load_identity();
        do_reset();
        pulse_start();
        repeat (9) tick();
        pulse_start();
        check_eq("t6_busy_mid", 32'(busy), 32'd1);
        wait_done("t6_done_seen", 300);
        start = 1'b1;
        tick();
        check_eq("t6_fin_start_ignored", 32'(busy), 32'd0);
        check_eq("t6_done_one_cycle", 32'(done), 32'd0);
        tick();
        start = 1'b0;
        check_eq("t6_idle_start_taken", 32'(busy), 32'd1);
        check_eq("t6_n_done_first", 32'(n_done), 32'd1);
        check_eq("t6_n_cmd_first", 32'(n_cmd), 32'd25);
        check_eq("t6_n_init_first", 32'(n_init), 32'd5);
        wait_done("t6_done2_seen", 300);
        tick();
        check_eq("t6_n_done_total", 32'(n_done), 32'd2);
        check_eq("t6_n_cmd_total", 32'(n_cmd), 32'd50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
